// File: rtl/uart_tx_framer.sv
// Purpose: serialise one byte into a UART frame (start, LSB-first data, optional parity, stop).
// Latency: line drops to the start bit on the accepting edge; frame lasts N*P cycles (N = 10 or 11).
// Backpressure: busy high for the whole frame; data_valid while busy is dropped, never queued.
module uart_tx_framer #(
  parameter int DATA_WIDTH = 8,
  parameter int PRE_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  data_valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRE_WIDTH-1:0]  prescale,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]            state;
  logic [DATA_WIDTH-1:0] data_q;     // frozen copy of the byte, used for parity
  logic [DATA_WIDTH-1:0] shift_q;    // data bits still to be put on the line
  logic                  par_en_q;
  logic                  par_typ_q;
  logic [PRE_WIDTH-1:0]  pre_q;      // bit period, already clamped to at least 1
  logic [PRE_WIDTH-1:0]  pre_cnt;    // 0..pre_q-1 within the current bit
  logic [BIT_W-1:0]      bit_cnt;    // data bit index, only meaningful in S_DATA
  logic                  accept;
  logic                  bit_end;
  logic                  parity_bit;

  assign accept     = (state == S_IDLE) && data_valid;
  // pre_q never reaches 0, so pre_q-1 cannot underflow and the counter stays below 2**PRE_WIDTH-1
  assign bit_end    = (pre_cnt == (pre_q - PRE_WIDTH'(1)));
  assign parity_bit = par_typ_q ? ~^data_q : ^data_q;

  // Freeze byte and line configuration at acceptance so mid-frame input changes are ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      pre_q     <= PRE_WIDTH'(1);
    end else if (accept) begin
      data_q    <= P_DATA;
      par_en_q  <= PAR_EN;
      par_typ_q <= PAR_TYP;
      pre_q     <= (prescale == '0) ? PRE_WIDTH'(1) : prescale;
    end
  end

  // Frame sequencer: drives the registered line and busy, advances one bit every pre_q cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      TX_OUT  <= 1'b1;
      busy    <= 1'b0;
      pre_cnt <= '0;
      bit_cnt <= '0;
      shift_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          TX_OUT <= 1'b1;
          if (accept) begin
            state   <= S_START;
            TX_OUT  <= 1'b0;
            busy    <= 1'b1;
            pre_cnt <= '0;
            bit_cnt <= '0;
            shift_q <= P_DATA;
          end
        end
        default: begin
          if (!bit_end) begin
            pre_cnt <= pre_cnt + PRE_WIDTH'(1);
          end else begin
            pre_cnt <= '0;
            case (state)
              S_START: begin
                state   <= S_DATA;
                TX_OUT  <= shift_q[0];
                shift_q <= shift_q >> 1;
              end
              S_DATA: begin
                if (bit_cnt == LAST_BIT) begin
                  bit_cnt <= '0;
                  if (par_en_q) begin
                    state  <= S_PARITY;
                    TX_OUT <= parity_bit;
                  end else begin
                    state  <= S_STOP;
                    TX_OUT <= 1'b1;
                  end
                end else begin
                  bit_cnt <= bit_cnt + BIT_W'(1);
                  TX_OUT  <= shift_q[0];
                  shift_q <= shift_q >> 1;
                end
              end
              S_PARITY: begin
                state  <= S_STOP;
                TX_OUT <= 1'b1;
              end
              default: begin
                // end of stop bit (or recovery from an unused encoding)
                state  <= S_IDLE;
                busy   <= 1'b0;
                TX_OUT <= 1'b1;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: frame-level reference model plus directed vectors.
// The model predicts the line from frame bit index = cycles_since_accept / P.
// A software UART decoder samples mid-bit to check loopback-style reception.
module tb_uart_tx_framer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] P_DATA = 8'h00;
  logic       data_valid = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [5:0] prescale = 6'd1;
  logic       TX_OUT;
  logic       busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_tx_framer #(.DATA_WIDTH(8), .PRE_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .P_DATA(P_DATA), .data_valid(data_valid),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .prescale(prescale),
    .TX_OUT(TX_OUT), .busy(busy)
  );

  // ---------------- reference model ----------------
  logic        m_busy  = 1'b0;
  int          m_cnt   = 0;
  int          m_p     = 1;
  int          m_n     = 10;
  logic [10:0] m_frame = '1;

  // Frame as a bit vector, index 0 = start bit; parity chosen by counting ones
  function automatic logic [10:0] build_frame(logic [7:0] d, logic pen, logic ptyp);
    logic [10:0] f;
    int ones;
    f = '1;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = d[i];
      ones += int'(d[i]);
    end
    if (pen) f[9] = ptyp ? ((ones % 2) == 0) : ((ones % 2) == 1);
    return f;
  endfunction

  function automatic logic exp_tx();
    return m_busy ? m_frame[m_cnt / m_p] : 1'b1;
  endfunction

  // Model: a frame occupies N*P cycles from the accepting edge; idle otherwise
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
    end else if (m_busy) begin
      if (m_cnt + 1 >= m_n * m_p) begin
        m_busy <= 1'b0;
        m_cnt  <= 0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end else if (data_valid) begin
      m_busy  <= 1'b1;
      m_cnt   <= 0;
      m_p     <= (prescale == 6'd0) ? 1 : int'(prescale);
      m_n     <= PAR_EN ? 11 : 10;
      m_frame <= build_frame(P_DATA, PAR_EN, PAR_TYP);
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic pen, input logic ptyp, input logic [5:0] pre);
    @(negedge clk);
    P_DATA = d; PAR_EN = pen; PAR_TYP = ptyp; prescale = pre; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    check("accept_busy", {31'd0, busy}, 32'd1);
  endtask

  // Decode the frame mid-bit and count busy cycles; starts on the first negedge of the frame
  task automatic capture(input int p, output logic [10:0] bits, output int bc);
    bits = '1;
    bc = 0;
    while (busy === 1'b1 && bc < 3000) begin
      if ((bc % p) == (p / 2) && (bc / p) < 11) bits[bc / p] = TX_OUT;
      bc++;
      @(negedge clk);
    end
  endtask

  logic [10:0] bits;
  int          bc;
  logic [23:0] rec;
  logic [7:0]  d;

  initial begin
    // per-cycle comparison against the model
    fork
      forever begin
        @(negedge clk);
        check("line_vs_model", {31'd0, TX_OUT}, {31'd0, exp_tx()});
        check("busy_vs_model", {31'd0, busy}, {31'd0, m_busy});
      end
    join_none

    repeat (3) @(negedge clk);
    check("reset_line", {31'd0, TX_OUT}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // reset in the middle of data bit 4 (line low there for 8'h09)
    send(8'h09, 1'b1, 1'b0, 6'd8);
    repeat (42) @(negedge clk);
    check("pre_rst_line", {31'd0, TX_OUT}, 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_async_line", {31'd0, TX_OUT}, 32'd1);
    check("rst_async_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("post_rst_line", {31'd0, TX_OUT}, 32'd1);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    // even parity
    send(8'h09, 1'b1, 1'b0, 6'd8);
    capture(8, bits, bc);
    check("even_bits", {21'd0, bits}, 32'h412);
    check("even_cycles", bc, 88);

    // odd parity
    send(8'h09, 1'b1, 1'b1, 6'd8);
    capture(8, bits, bc);
    check("odd_bits", {21'd0, bits}, 32'h612);
    check("odd_cycles", bc, 88);

    // no parity
    send(8'h09, 1'b0, 1'b0, 6'd8);
    capture(8, bits, bc);
    check("nopar_bits", {22'd0, bits[9:0]}, 32'h212);
    check("nopar_cycles", bc, 80);

    // dropped request and mid-frame config change
    send(8'h09, 1'b1, 1'b0, 6'd8);
    fork
      capture(8, bits, bc);
      begin
        repeat (20) @(negedge clk);
        P_DATA = 8'hFF; PAR_TYP = 1'b1; prescale = 6'd3; data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
      end
    join
    check("drop_bits", {21'd0, bits}, 32'h412);
    check("drop_cycles", bc, 88);
    repeat (20) @(negedge clk);
    check("drop_no_second", {31'd0, busy}, 32'd0);

    // prescale 0 behaves as 1
    send(8'h5A, 1'b0, 1'b0, 6'd0);
    capture(1, bits, bc);
    check("pre0_bits", {22'd0, bits[9:0]}, 32'h2B4);
    check("pre0_cycles", bc, 10);

    // largest prescale
    send(8'h81, 1'b1, 1'b1, 6'd63);
    capture(63, bits, bc);
    check("pre63_bits", {21'd0, bits}, 32'h702);
    check("pre63_cycles", bc, 693);

    // back-to-back with data_valid held high, prescale 1
    @(negedge clk);
    PAR_EN = 1'b0; PAR_TYP = 1'b0; prescale = 6'd1; P_DATA = 8'hA5; data_valid = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      rec[i] = TX_OUT;
      if (i == 0) P_DATA = 8'h3C;
      if (i == 11) data_valid = 1'b0;
    end
    check("b2b_pattern", {8'd0, rec}, 32'hF3C74A);

    // loopback-style decode, every parity combination, random bytes
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 3; k++) begin
        d = 8'($urandom_range(0, 255));
        send(d, c[1], c[0], 6'd8);
        capture(8, bits, bc);
        check("rx_start", {31'd0, bits[0]}, 32'd0);
        check("rx_data", {24'd0, bits[8:1]}, {24'd0, d});
        if (c[1]) check("rx_parity", {31'd0, ^{d, bits[9]}}, {31'd0, c[0]});
        check("rx_stop", {31'd0, c[1] ? bits[10] : bits[9]}, 32'd1);
        check("rx_cycles", bc, c[1] ? 88 : 80);
      end
    end

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
